// File: rtl/pe_array_ctrl.sv
// Job sequencer for the 8x8 PE array: walks group x pixel x input tile,
// drives operand addresses, accumulates partial sums, streams output vectors.
module pe_array_ctrl #(
  parameter int ACC_W    = 32,
  parameter int LANES    = 8,
  parameter int MAX_WAIT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             cfg_k_tiles,
  input  logic [7:0]             cfg_n_groups,
  input  logic [15:0]            cfg_n_pix,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [15:0]            ifmap_addr,
  output logic [15:0]            weight_addr,
  output logic [7:0]             bias_addr,
  output logic                   bias_sel,
  output logic                   pe_en,
  input  logic                   pe_valid,
  input  logic [LANES*ACC_W-1:0] pe_ofmap,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out_data,
  output logic [15:0]            out_pix,
  output logic [7:0]             out_grp
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, WAIT, OUT, DONE
  } state_t;

  state_t                 state;
  logic [7:0]             kc, gc, k, grp;
  logic [15:0]            pc, pix;
  logic [15:0]            ibase, wbase;
  logic [WW-1:0]          wcnt;
  logic [LANES*ACC_W-1:0] acc;

  logic [15:0] kk;
  logic        last_k, last_pix, last_grp;

  assign kk       = {8'd0, kc};
  assign last_k   = (k == kc - 8'd1);
  assign last_pix = (pix == pc - 16'd1);
  assign last_grp = (grp == gc - 8'd1);
  assign out_data = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      kc          <= '0;
      gc          <= '0;
      pc          <= '0;
      k           <= '0;
      grp         <= '0;
      pix         <= '0;
      ibase       <= '0;
      wbase       <= '0;
      wcnt        <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ifmap_addr  <= '0;
      weight_addr <= '0;
      bias_addr   <= '0;
      bias_sel    <= 1'b0;
      pe_en       <= 1'b0;
      out_valid   <= 1'b0;
      out_pix     <= '0;
      out_grp     <= '0;
    end else begin
      pe_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          kc          <= cfg_k_tiles;
          gc          <= cfg_n_groups;
          pc          <= cfg_n_pix;
          k           <= '0;
          pix         <= '0;
          grp         <= '0;
          ibase       <= '0;
          wbase       <= '0;
          ifmap_addr  <= '0;
          weight_addr <= '0;
          bias_addr   <= '0;
          bias_sel    <= 1'b1;
          err         <= 1'b0;
          busy        <= 1'b1;
          if (cfg_k_tiles != 0 && cfg_n_groups != 0 && cfg_n_pix != 0)
            state <= FETCH;
          else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        FETCH: begin
          state <= ISSUE;
          pe_en <= 1'b1;
        end
        ISSUE: begin
          state <= WAIT;
          wcnt  <= '0;
        end
        WAIT: if (pe_valid) begin
          // first tile of an output starts a fresh sum
          for (int i = 0; i < LANES; i++)
            acc[i*ACC_W +: ACC_W] <=
              ((k == 8'd0) ? ACC_W'(0) : acc[i*ACC_W +: ACC_W])
              + pe_ofmap[i*ACC_W +: ACC_W];
          if (last_k) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_pix   <= pix;
            out_grp   <= grp;
          end else begin
            state       <= FETCH;
            k           <= k + 8'd1;
            ifmap_addr  <= ifmap_addr + 16'd1;
            weight_addr <= weight_addr + 16'd1;
            bias_sel    <= 1'b0;
          end
        end else if (wcnt == WW'(MAX_WAIT - 1)) begin
          state <= DONE;
          err   <= 1'b1;
          done  <= 1'b1;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          k         <= '0;
          bias_sel  <= 1'b1;
          if (!last_pix) begin
            state       <= FETCH;
            pix         <= pix + 16'd1;
            ibase       <= ibase + kk;
            ifmap_addr  <= ibase + kk;
            weight_addr <= wbase;
          end else begin
            pix        <= '0;
            ibase      <= '0;
            ifmap_addr <= '0;
            if (last_grp) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= FETCH;
              grp         <= grp + 8'd1;
              bias_addr   <= grp + 8'd1;
              wbase       <= wbase + kk;
              weight_addr <= wbase + kk;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
